axi_pack_mem_rd_rsp: RTL and testbench

- AXI4 read-only subordinate that terminates the standard-AXI read port driven by the pack converter: data reads, read-index fetches and write-index fetches.
- Queues AR requests and expands each burst into per-beat accesses on a 1-cycle-latency SRAM port.
- Returns R beats in request order with per-request ID, RESP and LAST.
- Used as the memory model behind the converter in block-level benches, and as the on-chip SRAM front end.

---
 rtl/axi_pack_mem_rd_rsp.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_pack_mem_rd_rsp.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_pack_mem_rd_rsp.sv
// AXI4 read-only subordinate in front of a 1-cycle-latency SRAM port.
// AR requests are queued, each burst is expanded into per-beat SRAM reads,
// and R beats come back strictly in AR acceptance order.
//
// state | meaning
// IDLE  | no active burst; load the next request (queue head, or AR input if queue empty)
// BEAT  | issuing SRAM reads for a legal FIXED/INCR burst, one per credit+grant
// ERR   | illegal burst type or size; emitting SLVERR beats with zero data
module axi_pack_mem_rd_rsp #(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned AxiIdWidth     = 6,
  parameter int unsigned NumOutstanding = 4,
  parameter int unsigned RspDepth       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [AxiIdWidth-1:0] ar_id_i,
  input  logic [AddrWidth-1:0]  ar_addr_i,
  input  logic [7:0]            ar_len_i,
  input  logic [2:0]            ar_size_i,
  input  logic [1:0]            ar_burst_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [AxiIdWidth-1:0] r_id_o,
  output logic [DataWidth-1:0]  r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic                  mem_req_o,
  output logic [AddrWidth-1:0]  mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DataWidth-1:0]  mem_rdata_i
);

  localparam int unsigned OffW    = $clog2(DataWidth / 8);
  localparam int unsigned ArPtrW  = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int unsigned ArCntW  = $clog2(NumOutstanding + 1);
  localparam int unsigned RspPtrW = $clog2(RspDepth);
  localparam int unsigned RspCntW = $clog2(RspDepth + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT = 2'd1, ERR = 2'd2} state_e;

  state_e state_q, state_d;

  // AR queue
  logic [AxiIdWidth-1:0] arq_id    [NumOutstanding];
  logic [AddrWidth-1:0]  arq_addr  [NumOutstanding];
  logic [7:0]            arq_len   [NumOutstanding];
  logic [2:0]            arq_size  [NumOutstanding];
  logic [1:0]            arq_burst [NumOutstanding];
  logic [ArPtrW-1:0]     arq_wr_q, arq_rd_q;
  logic [ArCntW-1:0]     arq_cnt_q, arq_cnt_d;
  logic                  ar_ready_q;
  logic                  ar_hs, arq_empty, arq_push, arq_pop, load;

  // request being loaded into the burst engine
  logic [AxiIdWidth-1:0] ld_id;
  logic [AddrWidth-1:0]  ld_addr;
  logic [7:0]            ld_len;
  logic [2:0]            ld_size;
  logic [1:0]            ld_burst;
  logic                  ld_illegal;

  // active burst
  logic [AxiIdWidth-1:0] cur_id_q;
  logic [AddrWidth-1:0]  cur_addr_q, next_addr, size_bytes;
  logic [8:0]            cur_rem_q;
  logic [2:0]            cur_size_q;
  logic [1:0]            cur_burst_q;
  logic                  last_beat, grant, credit, err_push;

  // inflight tag and response buffer
  logic                  inflight_q, infl_last_q;
  logic [AxiIdWidth-1:0] infl_id_q;
  logic [AxiIdWidth-1:0] rsp_id   [RspDepth];
  logic [DataWidth-1:0]  rsp_data [RspDepth];
  logic [1:0]            rsp_resp [RspDepth];
  logic                  rsp_last [RspDepth];
  logic [RspPtrW-1:0]    rsp_wr_q, rsp_rd_q;
  logic [RspCntW-1:0]    rsp_cnt_q;
  logic                  mem_push, rsp_push, r_pop;

  assign ar_ready_o = ar_ready_q;
  assign ar_hs      = ar_valid_i && ar_ready_q;
  assign arq_empty  = (arq_cnt_q == '0);
  assign load       = (state_q == IDLE) && (!arq_empty || ar_hs);
  assign arq_pop    = (state_q == IDLE) && !arq_empty;
  // an AR arriving while idle with an empty queue goes straight to the engine
  assign arq_push   = ar_hs && !((state_q == IDLE) && arq_empty);
  assign arq_cnt_d  = arq_cnt_q + ArCntW'(arq_push) - ArCntW'(arq_pop);

  assign ld_id      = arq_empty ? ar_id_i    : arq_id[arq_rd_q];
  assign ld_addr    = arq_empty ? ar_addr_i  : arq_addr[arq_rd_q];
  assign ld_len     = arq_empty ? ar_len_i   : arq_len[arq_rd_q];
  assign ld_size    = arq_empty ? ar_size_i  : arq_size[arq_rd_q];
  assign ld_burst   = arq_empty ? ar_burst_i : arq_burst[arq_rd_q];
  assign ld_illegal = ld_burst[1] || (32'(ld_size) > OffW);

  assign r_valid_o  = (rsp_cnt_q != '0);
  assign r_pop      = r_valid_o && r_ready_i;
  assign credit     = (32'(inflight_q) + 32'(rsp_cnt_q) - 32'(r_pop)) < RspDepth;
  assign last_beat  = (cur_rem_q == 9'd1);
  assign grant      = mem_req_o && mem_gnt_i;
  assign mem_addr_o = {cur_addr_q[AddrWidth-1:OffW], {OffW{1'b0}}};
  assign size_bytes = AddrWidth'(1) << cur_size_q;
  assign next_addr  = (cur_burst_q == 2'd1)
                    ? ((cur_addr_q & ~(size_bytes - AddrWidth'(1))) + size_bytes)
                    : cur_addr_q;

  assign mem_push   = mem_rvalid_i && inflight_q;
  assign rsp_push   = mem_push || err_push;

  assign r_id_o     = rsp_id[rsp_rd_q];
  assign r_data_o   = rsp_data[rsp_rd_q];
  assign r_resp_o   = rsp_resp[rsp_rd_q];
  assign r_last_o   = rsp_last[rsp_rd_q];

  // AR queue storage write
  always_ff @(posedge clk_i) begin
    if (arq_push) begin
      arq_id[arq_wr_q]    <= ar_id_i;
      arq_addr[arq_wr_q]  <= ar_addr_i;
      arq_len[arq_wr_q]   <= ar_len_i;
      arq_size[arq_wr_q]  <= ar_size_i;
      arq_burst[arq_wr_q] <= ar_burst_i;
    end
  end

  // AR queue pointers, occupancy and registered ready
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      arq_wr_q   <= '0;
      arq_rd_q   <= '0;
      arq_cnt_q  <= '0;
      ar_ready_q <= 1'b0;
    end else begin
      if (arq_push) arq_wr_q <= (arq_wr_q == ArPtrW'(NumOutstanding - 1)) ? '0 : arq_wr_q + ArPtrW'(1);
      if (arq_pop)  arq_rd_q <= (arq_rd_q == ArPtrW'(NumOutstanding - 1)) ? '0 : arq_rd_q + ArPtrW'(1);
      arq_cnt_q  <= arq_cnt_d;
      ar_ready_q <= (arq_cnt_d != ArCntW'(NumOutstanding));
    end
  end

  // burst FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // burst FSM next state, SRAM request and error-beat push
  always_comb begin
    state_d   = state_q;
    mem_req_o = 1'b0;
    err_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) state_d = ld_illegal ? ERR : BEAT;
      end
      BEAT: begin
        mem_req_o = credit;
        if (credit && mem_gnt_i && last_beat) state_d = IDLE;
      end
      ERR: begin
        err_push = credit;
        if (credit && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // active burst registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_id_q    <= '0;
      cur_addr_q  <= '0;
      cur_rem_q   <= '0;
      cur_size_q  <= '0;
      cur_burst_q <= '0;
    end else if (load) begin
      cur_id_q    <= ld_id;
      cur_addr_q  <= ld_addr;
      cur_rem_q   <= {1'b0, ld_len} + 9'd1;
      cur_size_q  <= ld_size;
      cur_burst_q <= ld_burst;
    end else if (grant) begin
      cur_addr_q  <= next_addr;
      cur_rem_q   <= cur_rem_q - 9'd1;
    end else if (err_push) begin
      cur_rem_q   <= cur_rem_q - 9'd1;
    end
  end

  // one-deep tag pipe matching the SRAM read latency
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q  <= 1'b0;
      infl_id_q   <= '0;
      infl_last_q <= 1'b0;
    end else begin
      inflight_q <= grant;
      if (grant) begin
        infl_id_q   <= cur_id_q;
        infl_last_q <= last_beat;
      end
    end
  end

  // response buffer; entries are reset so idle outputs read as zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RspDepth; i++) begin
        rsp_id[i]   <= '0;
        rsp_data[i] <= '0;
        rsp_resp[i] <= '0;
        rsp_last[i] <= 1'b0;
      end
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      rsp_cnt_q <= '0;
    end else begin
      if (rsp_push) begin
        rsp_id[rsp_wr_q]   <= mem_push ? infl_id_q   : cur_id_q;
        rsp_data[rsp_wr_q] <= mem_push ? mem_rdata_i : '0;
        rsp_resp[rsp_wr_q] <= mem_push ? 2'd0        : 2'd2;
        rsp_last[rsp_wr_q] <= mem_push ? infl_last_q : last_beat;
        rsp_wr_q <= (rsp_wr_q == RspPtrW'(RspDepth - 1)) ? '0 : rsp_wr_q + RspPtrW'(1);
      end
      if (r_pop) rsp_rd_q <= (rsp_rd_q == RspPtrW'(RspDepth - 1)) ? '0 : rsp_rd_q + RspPtrW'(1);
      rsp_cnt_q <= rsp_cnt_q + RspCntW'(rsp_push) - RspCntW'(r_pop);
    end
  end

endmodule

// File: tb/tb_axi_pack_mem_rd_rsp.sv
// Directed bench for axi_pack_mem_rd_rsp with a 1-cycle SRAM model.
module tb_axi_pack_mem_rd_rsp;
  localparam int AW = 48, DW = 512, IW = 6, DEPTH = 2;

  logic          clk_i = 1'b0, rst_i = 1'b0;
  logic          ar_valid_i = 1'b0, ar_ready_o;
  logic [IW-1:0] ar_id_i = '0;
  logic [AW-1:0] ar_addr_i = '0;
  logic [7:0]    ar_len_i = '0;
  logic [2:0]    ar_size_i = '0;
  logic [1:0]    ar_burst_i = '0;
  logic          r_valid_o, r_ready_i = 1'b1, r_last_o;
  logic [IW-1:0] r_id_o;
  logic [DW-1:0] r_data_o;
  logic [1:0]    r_resp_o;
  logic          mem_req_o, mem_gnt_i = 1'b1, mem_rvalid_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_rdata_i;

  int total = 0, bad = 0, cyc = 0;
  logic [IW-1:0] o_id[$];
  logic [DW-1:0] o_data[$];
  logic [1:0]    o_resp[$];
  logic          o_last[$];
  int            o_cyc[$];
  logic [AW-1:0] g_addr[$];
  int            g_cyc[$];
  int            req_cnt = 0, outst = 0, ovf = 0;

  axi_pack_mem_rd_rsp dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = a[31:0] ^ {8'(i + 1), 24'h0};
    return v;
  endfunction

  // SRAM model: data one cycle after req&&gnt
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_rvalid_i <= 1'b0;
      mem_rdata_i  <= '0;
    end else begin
      mem_rvalid_i <= mem_req_o && mem_gnt_i;
      mem_rdata_i  <= pat(mem_addr_o);
    end
  end

  // record R handshakes, SRAM grants and issued-but-unconsumed beats
  always @(negedge clk_i) begin
    if (rst_i) outst <= 0;
    else begin
      if (r_valid_o && r_ready_i) begin
        o_id.push_back(r_id_o);
        o_data.push_back(r_data_o);
        o_resp.push_back(r_resp_o);
        o_last.push_back(r_last_o);
        o_cyc.push_back(cyc);
      end
      if (mem_req_o) req_cnt <= req_cnt + 1;
      if (mem_req_o && mem_gnt_i) begin
        g_addr.push_back(mem_addr_o);
        g_cyc.push_back(cyc);
      end
      outst <= outst + int'(mem_req_o && mem_gnt_i) - int'(r_valid_o && r_ready_i);
      if (outst + int'(mem_req_o && mem_gnt_i) - int'(r_valid_o && r_ready_i) > DEPTH) ovf <= ovf + 1;
    end
  end

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int hs);
    @(posedge clk_i); #1;
    ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_size_i = size; ar_burst_i = burst;
    ar_valid_i = 1'b1;
    hs = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (ar_ready_o) begin
        @(posedge clk_i); #1;
        hs = cyc;
        break;
      end
    end
    ar_valid_i = 1'b0;
    total++;
    if (hs < 0) begin bad++; $display("FAIL ar_handshake id=%0h got=timeout want=accept", id); end
  endtask

  task automatic wait_beats(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (o_id.size() >= target) break;
      @(negedge clk_i); #1;
    end
    total++;
    if (o_id.size() < target) begin bad++; $display("FAIL beat_count got=%0d want=%0d", o_id.size(), target); end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    total++;
    if ({ar_ready_o, r_valid_o, mem_req_o, r_last_o, r_resp_o} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000000", {ar_ready_o, r_valid_o, mem_req_o, r_last_o, r_resp_o});
    end
    total++;
    if (r_id_o !== '0 || r_data_o !== '0 || mem_addr_o !== '0) begin
      bad++; $display("FAIL reset_data got id=%0h addr=%0h want=0", r_id_o, mem_addr_o);
    end
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    total++;
    if (ar_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ar_ready_o); end
  endtask

  task automatic test_single_beat();
    int hs, ib, gb;
    ib = o_id.size(); gb = g_addr.size();
    send_ar(6'd5, 48'h1040, 8'd0, 3'd6, 2'd1, hs);
    wait_beats(ib + 1, 20);
    repeat (3) @(negedge clk_i);
    total++; if (o_id.size() != ib + 1) begin bad++; $display("FAIL single_count got=%0d want=%0d", o_id.size() - ib, 1); end
    total++; if (g_addr[gb] !== 48'h1040) begin bad++; $display("FAIL single_addr got=%0h want=1040", g_addr[gb]); end
    total++; if (g_cyc[gb] != hs) begin bad++; $display("FAIL single_req_lat got=%0d want=%0d", g_cyc[gb] - hs, 0); end
    total++; if (o_cyc[ib] != hs + 2) begin bad++; $display("FAIL single_r_lat got=%0d want=%0d", o_cyc[ib] - hs, 2); end
    total++; if (o_id[ib] !== 6'd5) begin bad++; $display("FAIL single_id got=%0h want=5", o_id[ib]); end
    total++; if (o_data[ib] !== pat(48'h1040)) begin bad++; $display("FAIL single_data got=%0h want=%0h", o_data[ib][31:0], 32'h0100_1040); end
    total++; if (o_resp[ib] !== 2'd0 || o_last[ib] !== 1'b1) begin
      bad++; $display("FAIL single_resp_last got=%0d/%b want=0/1", o_resp[ib], o_last[ib]);
    end
  endtask

  task automatic test_burst_backpressure();
    int hs, ib, gb;
    logic [3:0] rp;
    logic [2:0] gp;
    rp = 4'b1001; gp = 3'b011;
    ib = o_id.size(); gb = g_addr.size();
    send_ar(6'd7, 48'h2000, 8'd3, 3'd6, 2'd1, hs);
    for (int k = 0; k < 80; k++) begin
      @(posedge clk_i); #1;
      r_ready_i = rp[k % 4];
      mem_gnt_i = gp[k % 3];
      @(negedge clk_i); #1;
      if (o_id.size() >= ib + 4) break;
    end
    r_ready_i = 1'b1; mem_gnt_i = 1'b1;
    wait_beats(ib + 4, 10);
    repeat (3) @(negedge clk_i);
    total++; if (g_addr.size() != gb + 4) begin bad++; $display("FAIL burst_grants got=%0d want=4", g_addr.size() - gb); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (g_addr[gb + i] !== 48'h2000 + 48'(i * 64)) begin
        bad++; $display("FAIL burst_addr[%0d] got=%0h want=%0h", i, g_addr[gb + i], 48'h2000 + 48'(i * 64));
      end
      total++;
      if (o_id[ib + i] !== 6'd7 || o_last[ib + i] !== (i == 3) || o_data[ib + i] !== pat(48'h2000 + 48'(i * 64))) begin
        bad++; $display("FAIL burst_beat[%0d] got id=%0h last=%b want id=7 last=%b", i, o_id[ib + i], o_last[ib + i], i == 3);
      end
    end
    total++; if (ovf != 0) begin bad++; $display("FAIL burst_credit got=%0d want=0", ovf); end
  endtask

  task automatic test_narrow();
    int hs, ib, gb;
    logic [AW-1:0] exp_a[4];
    exp_a = '{48'h1000, 48'h1040, 48'h1000, 48'h1000};
    ib = o_id.size(); gb = g_addr.size();
    send_ar(6'd3, 48'h103C, 8'd1, 3'd2, 2'd1, hs);
    send_ar(6'd4, 48'h103C, 8'd1, 3'd2, 2'd0, hs);
    wait_beats(ib + 4, 40);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (g_addr[gb + i] !== exp_a[i]) begin bad++; $display("FAIL narrow_addr[%0d] got=%0h want=%0h", i, g_addr[gb + i], exp_a[i]); end
      total++;
      if (o_data[ib + i] !== pat(exp_a[i]) || o_last[ib + i] !== (i % 2 == 1) || o_id[ib + i] !== ((i < 2) ? 6'd3 : 6'd4)) begin
        bad++; $display("FAIL narrow_beat[%0d] got id=%0h last=%b", i, o_id[ib + i], o_last[ib + i]);
      end
    end
  endtask

  task automatic test_error();
    int hs, ib, rq;
    for (int t = 0; t < 2; t++) begin
      ib = o_id.size(); rq = req_cnt;
      if (t == 0) send_ar(6'd9, 48'h3000, 8'd2, 3'd6, 2'd2, hs);
      else        send_ar(6'd10, 48'h3000, 8'd2, 3'd7, 2'd1, hs);
      wait_beats(ib + 3, 30);
      repeat (5) @(negedge clk_i);
      #1;
      total++; if (o_id.size() != ib + 3) begin bad++; $display("FAIL err%0d_count got=%0d want=3", t, o_id.size() - ib); end
      total++; if (req_cnt != rq) begin bad++; $display("FAIL err%0d_mem_req got=%0d want=0", t, req_cnt - rq); end
      for (int i = 0; i < 3; i++) begin
        total++;
        if (o_resp[ib + i] !== 2'd2 || o_data[ib + i] !== '0 || o_last[ib + i] !== (i == 2) || o_id[ib + i] !== 6'(9 + t)) begin
          bad++; $display("FAIL err%0d_beat[%0d] got resp=%0d last=%b id=%0h want resp=2 last=%b id=%0h",
                          t, i, o_resp[ib + i], o_last[ib + i], o_id[ib + i], i == 2, 9 + t);
        end
      end
    end
  endtask

  task automatic test_queue_full();
    int hs, ib, acc;
    logic [IW-1:0] ids[6];
    ids = '{6'd1, 6'd2, 6'h3E, 6'd3, 6'h3F, 6'd4};
    ib = o_id.size();
    r_ready_i = 1'b0;
    // one request occupies the burst engine, the next four fill the queue
    for (int i = 0; i < 5; i++) send_ar(ids[i], 48'h4000 + 48'(i * 256), 8'd3, 3'd6, 2'd1, hs);
    @(negedge clk_i);
    total++; if (ar_ready_o !== 1'b0) begin bad++; $display("FAIL qfull_ready got=%b want=0", ar_ready_o); end
    @(posedge clk_i); #1;
    ar_id_i = ids[5]; ar_addr_i = 48'h4500; ar_len_i = 8'd3; ar_size_i = 3'd6; ar_burst_i = 2'd1;
    ar_valid_i = 1'b1;
    repeat (4) @(negedge clk_i);
    total++; if (ar_ready_o !== 1'b0) begin bad++; $display("FAIL qfull_hold got=%b want=0", ar_ready_o); end
    r_ready_i = 1'b1;
    acc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (ar_ready_o) begin @(posedge clk_i); #1; acc = 1; break; end
    end
    ar_valid_i = 1'b0;
    total++; if (acc != 1) begin bad++; $display("FAIL qfull_sixth got=timeout want=accept"); end
    wait_beats(ib + 24, 300);
    for (int i = 0; i < 24; i++) begin
      total++;
      if (o_id[ib + i] !== ids[i / 4] || o_last[ib + i] !== (i % 4 == 3) ||
          o_data[ib + i] !== pat(48'h4000 + 48'((i / 4) * 256 + (i % 4) * 64))) begin
        bad++; $display("FAIL qfull_beat[%0d] got id=%0h last=%b want id=%0h last=%b",
                        i, o_id[ib + i], o_last[ib + i], ids[i / 4], i % 4 == 3);
      end
    end
    total++; if (ovf != 0) begin bad++; $display("FAIL qfull_credit got=%0d want=0", ovf); end
  endtask

  task automatic test_back_to_back();
    int hs, ib, gb;
    ib = o_id.size(); gb = g_addr.size();
    send_ar(6'd12, 48'h6000, 8'd7, 3'd6, 2'd1, hs);
    wait_beats(ib + 8, 40);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (g_cyc[gb + i] != hs + i || o_cyc[ib + i] != hs + 2 + i) begin
        bad++; $display("FAIL b2b_timing[%0d] got req=%0d r=%0d want req=%0d r=%0d",
                        i, g_cyc[gb + i] - hs, o_cyc[ib + i] - hs, i, i + 2);
      end
    end
    total++; if (o_last[ib + 7] !== 1'b1 || o_last[ib + 6] !== 1'b0) begin
      bad++; $display("FAIL b2b_last got=%b%b want=01", o_last[ib + 6], o_last[ib + 7]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int hs, ib, gb, seen;
    gb = g_addr.size();
    send_ar(6'd20, 48'h8000, 8'd7, 3'd6, 2'd1, hs);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (g_addr.size() >= gb + 2) begin seen = 1; break; end
      @(negedge clk_i); #1;
    end
    total++; if (seen != 1) begin bad++; $display("FAIL rstmid_beat2 got=timeout want=grant"); end
    rst_i = 1'b1;
    #1;
    total++; if (r_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_outputs got valid=%b req=%b want=0/0", r_valid_o, mem_req_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    total++; if (ar_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", ar_ready_o); end
    ib = o_id.size(); gb = g_addr.size();
    send_ar(6'd21, 48'h9000, 8'd0, 3'd6, 2'd1, hs);
    wait_beats(ib + 1, 20);
    repeat (4) @(negedge clk_i);
    #1;
    total++; if (o_id.size() != ib + 1 || o_cyc[ib] != hs + 2) begin
      bad++; $display("FAIL rstmid_single got beats=%0d lat=%0d want beats=1 lat=2", o_id.size() - ib, o_cyc[ib] - hs);
    end
    total++; if (o_id[ib] !== 6'd21 || o_data[ib] !== pat(48'h9000) || o_last[ib] !== 1'b1) begin
      bad++; $display("FAIL rstmid_beat got id=%0h last=%b want id=15 last=1", o_id[ib], o_last[ib]);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_beat();
    test_burst_backpressure();
    test_narrow();
    test_error();
    test_queue_full();
    test_back_to_back();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
